// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, in-order response buffer, redirect flush.
// Optional misaligned-redirect fault path enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] ResetPC        = 32'h0000_0000,
   parameter int          FifoDepth      = 2,
   parameter int          MaxOutstanding = 2
) (
   input  logic        iClk,
   input  logic        iRst_n,
   output logic        oMemReq,
   output logic [31:0] oMemAddr,
   input  logic        iMemGnt,
   input  logic        iMemRValid,
   input  logic [31:0] iMemRData,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC,
   output logic        oValid,
   input  logic        iReady,
   output logic [31:0] oINS,
   output logic [31:0] oPC,
   output logic        oMisalign
);
   localparam int          AW  = $clog2(FifoDepth);
   localparam int          CW  = $clog2(FifoDepth + 1);
   localparam int          OW  = $clog2(MaxOutstanding + 1);
   localparam logic [31:0] FD  = FifoDepth;
   localparam logic [31:0] MO  = MaxOutstanding;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   pc_next_q, pc_next_d, resp_pc_q, resp_pc_d;
   logic [OW-1:0] live_q, live_d, drop_q, drop_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   fifo_ins_q [FifoDepth];
   logic [31:0]   fifo_ins_d [FifoDepth];
   logic [31:0]   fifo_pc_q  [FifoDepth];
   logic [31:0]   fifo_pc_d  [FifoDepth];
   logic          run, credit_ok, grant, keep, drp, push, pop, fifo_vld;
   logic [31:0]   redir_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic {RUN, HALT} state_e;
   state_e      state_q, state_d;
   logic        mis_vld_q, mis_vld_d;
   logic [31:0] mis_pc_q, mis_pc_d;
   logic        misaligned;

   assign run        = (state_q == RUN);
   assign misaligned = (iRedirectPC[1:0] != 2'b00);
`else
   logic unused_pc_lsb;

   assign run           = 1'b1;
   assign unused_pc_lsb = ^iRedirectPC[1:0];
`endif

   assign redir_pc  = {iRedirectPC[31:2], 2'b00};
   assign fifo_vld  = (cnt_q != '0);
   // Credit covers both buffer space for kept data and the memory's outstanding limit.
   assign credit_ok = (32'(cnt_q) + 32'(live_q) < FD) && (32'(live_q) + 32'(drop_q) < MO);
   assign oMemReq   = iRst_n && run && !iRedirect && credit_ok;
   assign oMemAddr  = pc_next_q;
   assign grant     = oMemReq && iMemGnt;
   assign drp       = iMemRValid && (drop_q != '0);
   assign keep      = iMemRValid && (drop_q == '0) && (live_q != '0);
   assign push      = keep && !iRedirect;
   assign pop       = fifo_vld && iReady && !iRedirect;

   always_comb begin
      oValid    = fifo_vld;
      oINS      = fifo_vld ? fifo_ins_q[rd_ptr_q] : NOP;
      oPC       = fifo_vld ? fifo_pc_q[rd_ptr_q]  : resp_pc_q;
      oMisalign = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (mis_vld_q) begin
         oValid    = 1'b1;
         oINS      = NOP;
         oPC       = mis_pc_q;
         oMisalign = 1'b1;
      end
`endif
   end

   always_comb begin
      pc_next_d  = pc_next_q;
      resp_pc_d  = resp_pc_q;
      live_d     = live_q;
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      fifo_ins_d = fifo_ins_q;
      fifo_pc_d  = fifo_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
      state_d    = state_q;
      mis_vld_d  = mis_vld_q;
      mis_pc_d   = mis_pc_q;
`endif
      if (iRedirect) begin
         // Everything still in flight becomes stale; a response landing now is consumed from the right counter.
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         cnt_d     = '0;
         live_d    = '0;
         drop_d    = drop_q + live_q - OW'(keep) - OW'(drp);
         pc_next_d = redir_pc;
         resp_pc_d = redir_pc;
`ifdef FETCH_ALIGN_CHECK_EN
         state_d   = misaligned ? HALT : RUN;
         mis_vld_d = misaligned;
         mis_pc_d  = iRedirectPC;
`endif
      end else begin
         if (grant) pc_next_d = pc_next_q + 32'd4;
         live_d = live_q + OW'(grant) - OW'(keep);
         drop_d = drop_q - OW'(drp);
         if (push) begin
            fifo_ins_d[wr_ptr_q] = iMemRData;
            fifo_pc_d[wr_ptr_q]  = resp_pc_q;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            resp_pc_d            = resp_pc_q + 32'd4;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + CW'(push) - CW'(pop);
`ifdef FETCH_ALIGN_CHECK_EN
         if (mis_vld_q && iReady) mis_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         pc_next_q <= ResetPC;
         resp_pc_q <= ResetPC;
         live_q    <= '0;
         drop_q    <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         state_q   <= RUN;
         mis_vld_q <= 1'b0;
         mis_pc_q  <= ResetPC;
`endif
      end else begin
         pc_next_q <= pc_next_d;
         resp_pc_q <= resp_pc_d;
         live_q    <= live_d;
         drop_q    <= drop_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
`ifdef FETCH_ALIGN_CHECK_EN
         state_q   <= state_d;
         mis_vld_q <= mis_vld_d;
         mis_pc_q  <= mis_pc_d;
`endif
      end
   end

   // Buffer storage is qualified by cnt_q, so it needs no reset.
   always_ff @(posedge iClk) begin
      fifo_ins_q <= fifo_ins_d;
      fifo_pc_q  <= fifo_pc_d;
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based memory/decoder model.
module tb_fetch_unit;
   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          FD  = 2;
   localparam int          MO  = 2;

   typedef struct {logic [31:0] addr; int due; int ep;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;

   logic iClk = 1'b0, iRst_n = 1'b0;
   logic oMemReq, iMemGnt, iMemRValid, iRedirect, oValid, iReady, oMisalign;
   logic [31:0] oMemAddr, iMemRData, iRedirectPC, oINS, oPC;

   fetch_unit #(.ResetPC(32'h0), .FifoDepth(FD), .MaxOutstanding(MO)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemGnt(iMemGnt),
      .iMemRValid(iMemRValid), .iMemRData(iMemRData), .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
      .oValid(oValid), .iReady(iReady), .oINS(oINS), .oPC(oPC), .oMisalign(oMisalign));

   always #5 iClk = ~iClk;

   int          n_chk = 0, n_pass = 0, cyc = 0, lat = 1, gnt_pct = 100, epoch = 0;
   logic [31:0] mpc = 32'h0, mis_pc = 32'h0;
   bit          halt = 0, mis_vld = 0;
   req_t        pend[$];
   ent_t        expq[$];
   logic        s_req, s_valid, s_mis;
   logic [31:0] s_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin n_pass++; end
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int live_cnt();
      int n = 0;
      foreach (pend[i]) if (pend[i].ep == epoch) n++;
      return n;
   endfunction

   // One clock: drive at negedge, check just after, then advance the model to what the next edge must produce.
   task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
      bit rv, gnt, exp_req, exp_vld, mis;
      @(negedge iClk);
      cyc++;
      rv  = (pend.size() > 0) && (pend[0].due <= cyc);
      gnt = ($urandom_range(99) < gnt_pct);
      iMemRValid  = rv;
      iMemRData   = rv ? (pend[0].addr ^ K) : $urandom;
      iMemGnt     = gnt;
      iReady      = rdy;
      iRedirect   = redir;
      iRedirectPC = rpc;
      #1;
      s_req = oMemReq; s_valid = oValid; s_pc = oPC; s_mis = oMisalign;
      exp_req = !halt && !redir && (expq.size() + live_cnt() < FD) && (pend.size() < MO);
      exp_vld = (expq.size() != 0) || mis_vld;
      chk("mem_req", oMemReq, exp_req);
      if (exp_req) chk("mem_addr", oMemAddr, mpc);
      chk("valid", oValid, exp_vld);
      if (mis_vld) begin
         chk("mis_flag", oMisalign, 1);
         chk("mis_pc", oPC, mis_pc);
         chk("mis_ins", oINS, NOP);
      end else if (expq.size() != 0) begin
         chk("out_pc", oPC, expq[0].pc);
         chk("out_ins", oINS, expq[0].ins);
         chk("no_mis", oMisalign, 0);
      end else begin
         chk("empty_ins", oINS, NOP);
      end
      if (redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
         mis = (rpc[1:0] != 2'b00);
`else
         mis = 0;
`endif
         epoch++;
         expq.delete();
         halt = mis; mis_vld = mis; mis_pc = rpc;
         mpc = {rpc[31:2], 2'b00};
      end else begin
         if (exp_vld && rdy) begin
            if (mis_vld) mis_vld = 0;
            else void'(expq.pop_front());
         end
         if (rv && pend[0].ep == epoch)
            expq.push_back('{pc: pend[0].addr, ins: pend[0].addr ^ K});
      end
      if (rv) void'(pend.pop_front());
      if (exp_req && gnt) begin
         pend.push_back('{addr: mpc, due: cyc + lat, ep: epoch});
         mpc += 32'd4;
      end
   endtask

   initial begin
      bit seen, done;
      logic [31:0] tgt;
      iMemGnt = 0; iMemRValid = 0; iMemRData = 0; iRedirect = 0; iRedirectPC = 0; iReady = 0;
      repeat (3) @(negedge iClk);
      #1;
      chk("rst_req", oMemReq, 0);
      chk("rst_valid", oValid, 0);
      chk("rst_ins", oINS, NOP);
      chk("rst_pc", oPC, 32'h0);
      chk("rst_mis", oMisalign, 0);
      @(negedge iClk);
      iRst_n = 1'b1;
      #1;
      chk("first_req", oMemReq, 1);
      chk("first_addr", oMemAddr, 32'h0);

      // Streaming with single-cycle memory
      repeat (20) step(1, 0, 0);

      // Decoder stalls: buffer fills with 0,4 and requests stop
      step(1, 1, 32'h0);
      repeat (10) step(0, 0, 0);
      chk("stall_valid", s_valid, 1);
      chk("stall_pc", s_pc, 32'h0);
      chk("stall_req", s_req, 0);
      repeat (6) step(1, 0, 0);

      // Long latency, redirect with two requests in flight
      lat = 3;
      step(1, 1, 32'h40);
      repeat (8) step(1, 0, 0);
      step(1, 1, 32'h100);
      s_valid = 0;
      for (int i = 0; i < 30 && !s_valid; i++) step(1, 0, 0);
      chk("redir_valid", s_valid, 1);
      chk("redir_pc", s_pc, 32'h100);

      // Redirect while a response lands and the head pops
      lat = 1;
      step(1, 1, 32'h200);
      repeat (5) step(1, 0, 0);
      step(1, 1, 32'h300);
      s_valid = 0;
      for (int i = 0; i < 30 && !s_valid; i++) step(1, 0, 0);
      chk("redir2_pc", s_pc, 32'h300);

      // Address wrap past the top of memory
      step(1, 1, 32'hFFFF_FFF8);
      seen = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         step(1, 0, 0);
         if (s_valid) begin
            if (seen) begin chk("wrap_pc", s_pc, 32'h0); done = 1; end
            else if (s_pc == 32'hFFFF_FFFC) seen = 1;
         end
      end
      chk("wrap_done", done, 1);

`ifdef FETCH_ALIGN_CHECK_EN
      step(1, 1, 32'h102);
      repeat (4) step(0, 0, 0);
      chk("halt_valid", s_valid, 1);
      chk("halt_mis", s_mis, 1);
      chk("halt_pc", s_pc, 32'h102);
      chk("halt_req", s_req, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("halt_popped", s_valid, 0);
      step(1, 1, 32'h200);
      s_valid = 0;
      for (int i = 0; i < 30 && !s_valid; i++) step(1, 0, 0);
      chk("resume_pc", s_pc, 32'h200);
`endif

      // Random traffic
      gnt_pct = 70;
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) lat = $urandom_range(3, 1);
         if ($urandom_range(99) < 4) begin
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(3) != 0, 1, tgt);
         end else begin
            step($urandom_range(3) != 0, 0, 0);
         end
      end
      repeat (20) step(1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
